// File: rtl/pe_psum_acc.sv
// Partial-sum accumulator behind the PE add tree: sums beat_num add-tree
// outputs into one dot-product result and hands it out over valid/ready.
module pe_psum_acc #(
  parameter int DW    = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] beat_num,
  input  logic             psum_vld,
  input  logic [DW-1:0]    psum,
  output logic             psum_rdy,
  output logic             result_vld,
  output logic [DW-1:0]    result,
  input  logic             result_rdy,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where both valid and
  // ready are high; the producer holds data stable until that edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [DW-1:0]    acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] beat_num_q;
  logic             psum_rdy_q;
  logic             result_vld_q;
  logic             busy_q;

  logic psum_hs;
  logic last_beat;

  assign psum_hs   = psum_vld && psum_rdy_q;
  // beat_num_q is never 0 while in ACC, so the subtraction cannot underflow
  assign last_beat = (cnt_q == beat_num_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      beat_num_q   <= '0;
      psum_rdy_q   <= 1'b0;
      result_vld_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (beat_num != '0) begin
              beat_num_q <= beat_num;
              psum_rdy_q <= 1'b1;
              state_q    <= ACC;
            end else begin
              result_vld_q <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        ACC: begin
          if (psum_hs) begin
            acc_q <= acc_q + psum;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_beat) begin
              psum_rdy_q   <= 1'b0;
              result_vld_q <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        DONE: begin
          if (result_rdy) begin
            result_vld_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          psum_rdy_q   <= 1'b0;
          result_vld_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign psum_rdy   = psum_rdy_q;
  assign result_vld = result_vld_q;
  // acc is only cleared by the next start, so the result lingers after DONE
  assign result     = acc_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pe_psum_acc.sv
// Bench for pe_psum_acc: table of jobs plus hand-written corner sequences,
// with a scoreboard queue of expected results.
module tb_pe_psum_acc;
  localparam int DW    = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] beat_num = '0;
  logic             psum_vld = 1'b0;
  logic [DW-1:0]    psum = '0;
  logic             psum_rdy;
  logic             result_vld;
  logic [DW-1:0]    result;
  logic             result_rdy = 1'b0;
  logic             busy;
  logic [1:0]       dbg_state;

  pe_psum_acc #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .beat_num   (beat_num),
    .psum_vld   (psum_vld),
    .psum       (psum),
    .psum_rdy   (psum_rdy),
    .result_vld (result_vld),
    .result     (result),
    .result_rdy (result_rdy),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] beats[256];

  typedef struct {
    logic [CNT_W-1:0] n;
    int               gap;
    int               hold;
    logic [DW-1:0]    ps[4];
    logic [DW-1:0]    exp_res;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Called at a falling edge; pushes the model sum of beats[0..n-1].
  task automatic start_job(input logic [CNT_W-1:0] n);
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < int'(n); i++) s += beats[i];
    exp_q.push_back(s);
    start    = 1'b1;
    beat_num = n;
    @(negedge clk);
    start    = 1'b0;
    beat_num = CNT_W'($urandom_range(0, 255));
  endtask

  task automatic feed(input int n, input int gap);
    logic [DW-1:0] part;
    int t;
    part = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          psum_vld = 1'b0;
          psum     = $urandom;
          @(negedge clk);
          check("gap_acc_hold", result, part);
          check("gap_rdy_high", psum_rdy, 1);
        end
      end
      psum_vld = 1'b1;
      psum     = beats[i];
      t = 0;
      while (!psum_rdy && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!psum_rdy) timeout_fail("psum_rdy_wait");
      @(negedge clk);
      part += beats[i];
      check("running_acc", result, part);
    end
    psum_vld = 1'b0;
  endtask

  task automatic collect(input int hold);
    logic [DW-1:0] held;
    int t;
    t = 0;
    while (!result_vld && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!result_vld) timeout_fail("result_vld_wait");
    held = result;
    for (int h = 0; h < hold; h++) begin
      result_rdy = 1'b0;
      @(negedge clk);
      check("hold_vld", result_vld, 1);
      check("hold_val", result, held);
    end
    result_rdy = 1'b1;
    if (exp_q.size() == 0) begin
      timeout_fail("scoreboard_empty");
    end else begin
      check("scoreboard", result, exp_q.pop_front());
    end
    @(negedge clk);
    result_rdy = 1'b0;
    check("vld_drop", result_vld, 0);
    check("busy_drop", busy, 0);
    check("result_kept", result, held);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{n: 8'd4, gap: 0, hold: 0, ps: '{32'd10, 32'd20, 32'd30, 32'd40}, exp_res: 32'd100};
    vecs[1] = '{n: 8'd3, gap: 2, hold: 0, ps: '{32'd5, -32'sd7, 32'd1, 32'd0}, exp_res: 32'hFFFF_FFFF};
    vecs[2] = '{n: 8'd2, gap: 0, hold: 1, ps: '{32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0}, exp_res: 32'h8000_0000};
    vecs[3] = '{n: 8'd0, gap: 0, hold: 0, ps: '{32'd0, 32'd0, 32'd0, 32'd0}, exp_res: 32'd0};
    for (int v = 4; v < 6; v++) begin
      vecs[v].n    = 8'd4;
      vecs[v].gap  = $urandom_range(0, 2);
      vecs[v].hold = $urandom_range(0, 3);
      vecs[v].exp_res = '0;
      for (int i = 0; i < 4; i++) begin
        vecs[v].ps[i] = $urandom;
        vecs[v].exp_res += vecs[v].ps[i];
      end
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_psum_rdy", psum_rdy, 0);
    check("rst_result_vld", result_vld, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven jobs
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) beats[i] = vecs[v].ps[i];
      psum_vld = (vecs[v].n == 0);
      start_job(vecs[v].n);
      check("busy_after_start", busy, 1);
      if (vecs[v].n != 0) begin
        check("rdy_after_start", psum_rdy, 1);
        feed(int'(vecs[v].n), vecs[v].gap);
      end else begin
        check("zero_job_rdy_low", psum_rdy, 0);
        psum_vld = 1'b0;
      end
      check("vld_after_last", result_vld, 1);
      check("table_result", result, vecs[v].exp_res);
      collect(vecs[v].hold);
    end

    // result_rdy low for 5 cycles with a start pulse in DONE
    beats[0] = 32'd3;
    beats[1] = 32'd4;
    start_job(8'd2);
    feed(2, 0);
    for (int h = 0; h < 5; h++) begin
      result_rdy = 1'b0;
      start      = (h == 2);
      beat_num   = 8'd5;
      @(negedge clk);
      check("done_stall_vld", result_vld, 1);
      check("done_stall_val", result, 32'd7);
      check("done_stall_state", dbg_state, 2);
    end
    start = 1'b0;
    collect(0);
    @(negedge clk);
    check("start_in_done_ignored", busy, 0);

    // start coinciding with the result handshake is dropped
    beats[0] = 32'd11;
    start_job(8'd1);
    feed(1, 0);
    result_rdy = 1'b1;
    start      = 1'b1;
    beat_num   = 8'd1;
    check("hs_cycle_result", result, exp_q.pop_front());
    @(negedge clk);
    result_rdy = 1'b0;
    start      = 1'b0;
    check("hs_start_busy", busy, 0);
    check("hs_start_rdy", psum_rdy, 0);
    @(negedge clk);
    check("hs_start_still_idle", dbg_state, 0);

    // Maximum beat count
    for (int i = 0; i < 255; i++) beats[i] = $urandom;
    start_job(8'd255);
    feed(255, 0);
    check("max_vld", result_vld, 1);
    collect(0);

    // Asynchronous reset mid-job
    beats[0] = 32'd1; beats[1] = 32'd2; beats[2] = 32'd3; beats[3] = 32'd4;
    start_job(8'd4);
    feed(2, 0);
    psum_vld = 1'b1;
    psum     = beats[2];
    #2 rst_n = 1'b0;
    #1;
    check("arst_psum_rdy", psum_rdy, 0);
    check("arst_result_vld", result_vld, 0);
    check("arst_result", result, 0);
    check("arst_busy", busy, 0);
    exp_q.delete();
    @(negedge clk);
    psum_vld = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    beats[0] = 32'd9;
    start_job(8'd1);
    feed(1, 0);
    check("post_rst_result", result, 32'd9);
    collect(0);

    if (exp_q.size() != 0) timeout_fail("scoreboard_leftover");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
